// File: rtl/datapath_src_muxn_arb_pkg.sv
// Shared types and constants for the N-source packet-aware datapath mux.
package datapath_src_muxn_arb_pkg;

   localparam int unsigned DefDwid   = 24;
   localparam int unsigned DefChNum  = 32;
   localparam int unsigned MaxSrcNum = 16;

   // One beat at the default geometry.
   typedef logic [DefChNum-1:0][DefDwid-1:0] beat_t;

   // Packet lock FSM encoding.
   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StLock = 1'b1;

endpackage

// File: rtl/datapath_src_muxn_arb_rr_arb_pick.sv
// Combinational circular priority picker: first set request at or after ptr_i, wrapping.
module datapath_src_muxn_arb_rr_arb_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   logic [W:0]   sum;
   logic [W-1:0] pos;

   // Scan ptr_i, ptr_i+1, ... modulo N; ptr_i < N keeps the sum below 2N.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      sum     = '0;
      pos     = '0;
      for (int k = 0; k < int'(N); k++) begin
         sum = {1'b0, ptr_i} + (W+1)'(k);
         if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
         end
         pos = sum[W-1:0];
         if (!found_o && req_i[pos]) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
      end
   end

endmodule

// File: rtl/datapath_src_muxn_arb.sv
// N-source packet-aware mux with registered output; grant is held for a whole packet.
module datapath_src_muxn_arb
   import datapath_src_muxn_arb_pkg::*;
#(
   parameter int unsigned DWID    = 24,
   parameter int unsigned CH_NUM  = 32,
   parameter int unsigned SRC_NUM = 4,
   localparam int unsigned SIDX_W = $clog2(SRC_NUM)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     mode,
   input  logic [SIDX_W-1:0]                        sel,
   input  logic [SRC_NUM-1:0]                       src_valid,
   input  logic [SRC_NUM-1:0]                       src_last,
   input  logic [SRC_NUM-1:0][CH_NUM-1:0][DWID-1:0] src_data,
   output logic [SRC_NUM-1:0]                       src_ready,
   output logic                                     dst_valid,
   output logic                                     dst_last,
   output logic [CH_NUM-1:0][DWID-1:0]              dst_data,
   output logic [SIDX_W-1:0]                        dst_src_id,
   input  logic                                     dst_ready,
   output logic                                     busy
);

   if (SRC_NUM < 2 || SRC_NUM > MaxSrcNum) begin : g_bad_src_num
      $error("SRC_NUM must be in 2..16");
   end

   logic [0:0]              state_q, state_d;
   logic [SIDX_W-1:0]       lock_src_q, lock_src_d;
   logic                    lock_mode_q, lock_mode_d;
   logic [SIDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                    dst_valid_q;
   logic                    dst_last_q;
   logic [CH_NUM-1:0][DWID-1:0] dst_data_q;
   logic [SIDX_W-1:0]       dst_src_id_q;

   logic [SIDX_W-1:0]       rr_idx;
   logic                    rr_found;
   logic [SIDX_W-1:0]       cur_src;
   logic                    cand_valid;
   logic                    eff_mode;
   logic                    can_take;
   logic                    accept;
   logic                    acc_last;

   datapath_src_muxn_arb_rr_arb_pick #(
      .N (SRC_NUM),
      .W (SIDX_W)
   ) u_pick (
      .req_i   (src_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (rr_idx),
      .found_o (rr_found)
   );

   // Candidate source: locked source mid-packet, otherwise static select or round-robin pick.
   always_comb begin
      cand_valid = 1'b0;
      cur_src    = '0;
      if (state_q == StLock) begin
         cand_valid = 1'b1;
         cur_src    = lock_src_q;
      end else if (!mode) begin
         if (32'(sel) < SRC_NUM) begin
            cand_valid = 1'b1;
            cur_src    = sel;
         end
      end else begin
         cand_valid = rr_found;
         cur_src    = rr_idx;
      end
   end

   // Handshake decode toward the sources.
   always_comb begin
      // mode is only honoured in idle; a locked packet keeps the mode it started with
      eff_mode  = (state_q == StLock) ? lock_mode_q : mode;
      can_take  = !dst_valid_q || dst_ready;
      src_ready = (cand_valid && can_take) ? (SRC_NUM'(1) << cur_src) : '0;
      accept    = cand_valid && can_take && src_valid[cur_src];
      acc_last  = src_last[cur_src];
   end

   // Lock FSM and round-robin pointer next state.
   always_comb begin
      state_d     = state_q;
      lock_src_d  = lock_src_q;
      lock_mode_d = lock_mode_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         if (state_q == StIdle && !acc_last) begin
            state_d     = StLock;
            lock_src_d  = cur_src;
            lock_mode_d = mode;
         end else if (state_q == StLock && acc_last) begin
            state_d = StIdle;
         end
         if (acc_last && eff_mode) begin
            rr_ptr_d = (cur_src == SIDX_W'(SRC_NUM - 1)) ? '0 : cur_src + 1'b1;
         end
      end
   end

   // Lock FSM and pointer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         lock_src_q  <= '0;
         lock_mode_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         lock_src_q  <= lock_src_d;
         lock_mode_q <= lock_mode_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Output register: a new beat replaces the old one in the same cycle it drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_valid_q  <= 1'b0;
         dst_last_q   <= 1'b0;
         dst_data_q   <= '0;
         dst_src_id_q <= '0;
      end else if (accept) begin
         dst_valid_q  <= 1'b1;
         dst_last_q   <= acc_last;
         dst_data_q   <= src_data[cur_src];
         dst_src_id_q <= cur_src;
      end else if (dst_ready) begin
         dst_valid_q <= 1'b0;
      end
   end

   assign dst_valid  = dst_valid_q;
   assign dst_last   = dst_last_q;
   assign dst_data   = dst_data_q;
   assign dst_src_id = dst_src_id_q;
   assign busy       = (state_q == StLock);

endmodule

// File: tb/tb_datapath_src_muxn_arb.sv
// Scoreboard bench for datapath_src_muxn_arb (4-source instance plus a 3-source instance).
module tb_datapath_src_muxn_arb;
   import datapath_src_muxn_arb_pkg::*;

   localparam int NS = 4;

   typedef struct {
      logic  last;
      beat_t data;
   } src_beat_t;

   typedef struct {
      logic [1:0] id;
      logic       last;
      beat_t      data;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             mode;
   logic [1:0]       sel;
   logic [NS-1:0]    src_valid;
   logic [NS-1:0]    src_last;
   beat_t [NS-1:0]   src_data;
   logic [NS-1:0]    src_ready;
   logic             dst_valid;
   logic             dst_last;
   beat_t            dst_data;
   logic [1:0]       dst_src_id;
   logic             dst_ready;
   logic             busy;

   logic             mode3;
   logic [1:0]       sel3;
   logic [2:0]       valid3;
   logic [2:0]       last3;
   beat_t [2:0]      data3;
   logic [2:0]       ready3;
   logic             dv3;
   logic             dl3;
   beat_t            dd3;
   logic [1:0]       id3;
   logic             dr3;
   logic             busy3;

   src_beat_t src_q[NS][$];
   exp_t      exp_q[$];
   exp_t      exp3_q[$];
   logic [NS-1:0] src_en;

   int errors = 0;
   int checks = 0;

   datapath_src_muxn_arb u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .sel        (sel),
      .src_valid  (src_valid),
      .src_last   (src_last),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .dst_valid  (dst_valid),
      .dst_last   (dst_last),
      .dst_data   (dst_data),
      .dst_src_id (dst_src_id),
      .dst_ready  (dst_ready),
      .busy       (busy)
   );

   datapath_src_muxn_arb #(
      .SRC_NUM (3)
   ) u_dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode3),
      .sel        (sel3),
      .src_valid  (valid3),
      .src_last   (last3),
      .src_data   (data3),
      .src_ready  (ready3),
      .dst_valid  (dv3),
      .dst_last   (dl3),
      .dst_data   (dd3),
      .dst_src_id (id3),
      .dst_ready  (dr3),
      .busy       (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic beat_t mk(input int s, input int n);
      beat_t b;
      for (int ch = 0; ch < int'(DefChNum); ch++) begin
         b[ch] = 24'((s << 16) | (n << 8) | ch);
      end
      return b;
   endfunction

   task automatic push_src(input int s, input int n, input logic l);
      src_beat_t b;
      b.last = l;
      b.data = mk(s, n);
      src_q[s].push_back(b);
   endtask

   task automatic push_exp(input int s, input int n, input logic l);
      exp_t e;
      e.id   = 2'(s);
      e.last = l;
      e.data = mk(s, n);
      exp_q.push_back(e);
   endtask

   // Present the head of each enabled source queue.
   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (src_en[i] && src_q[i].size() != 0) begin
            src_valid[i] = 1'b1;
            src_last[i]  = src_q[i][0].last;
            src_data[i]  = src_q[i][0].data;
         end else begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
            src_data[i]  = '0;
         end
      end
   endtask

   // One clock: note handshakes before the edge, retire them after it, re-present.
   task automatic tick();
      logic [NS-1:0] fire;
      src_beat_t     tmp;
      @(negedge clk);
      fire = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (fire[i]) tmp = src_q[i].pop_front();
      end
      drive();
      #1;
   endtask

   // Scoreboard for the 4-source instance: a beat is consumed when dst_valid && dst_ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dst_valid && dst_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard4: unexpected beat id=%0d ch0=%h, required no beat",
                     dst_src_id, dst_data[0]);
         end else begin
            e = exp_q.pop_front();
            if (dst_src_id !== e.id || dst_last !== e.last || dst_data !== e.data) begin
               errors++;
               $display("FAIL scoreboard4: id=%0d last=%0b ch0=%h, required id=%0d last=%0b ch0=%h",
                        dst_src_id, dst_last, dst_data[0], e.id, e.last, e.data[0]);
            end
         end
      end
   end

   // Scoreboard for the 3-source instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dv3 && dr3) begin
         checks++;
         if (exp3_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard3: unexpected beat id=%0d, required no beat", id3);
         end else begin
            e = exp3_q.pop_front();
            if (id3 !== e.id || dl3 !== e.last || dd3 !== e.data) begin
               errors++;
               $display("FAIL scoreboard3: id=%0d last=%0b ch0=%h, required id=%0d last=%0b ch0=%h",
                        id3, dl3, dd3[0], e.id, e.last, e.data[0]);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      mode = 1'b0; sel = 2'd0; dst_ready = 1'b1; src_en = '1;
      mode3 = 1'b0; sel3 = 2'd0; valid3 = '0; last3 = '0; data3 = '0; dr3 = 1'b1;
      drive();
      #12;
      checks++;
      if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_dst_valid: %b, required 0", dst_valid); end
      checks++;
      if (dst_last !== 1'b0) begin errors++; $display("FAIL reset_dst_last: %b, required 0", dst_last); end
      checks++;
      if (dst_data !== '0) begin errors++; $display("FAIL reset_dst_data: ch0=%h, required 0", dst_data[0]); end
      checks++;
      if (dst_src_id !== 2'd0) begin errors++; $display("FAIL reset_src_id: %0d, required 0", dst_src_id); end
      checks++;
      if (busy !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: %b/%b, required 0/0", busy, busy3); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic test_static_sel();
      mode = 1'b0; sel = 2'd2; dst_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         push_src(2, n, n == 2);
         push_exp(2, n, n == 2);
      end
      drive();
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (src_ready !== 4'b0100) begin errors++; $display("FAIL static_src_ready: %b, required 0100", src_ready); end
         tick();
         checks++;
         if (busy !== 1'(k < 2)) begin errors++; $display("FAIL static_busy beat %0d: %b, required %b", k, busy, 1'(k < 2)); end
         checks++;
         if (dst_valid !== 1'b1 || dst_src_id !== 2'd2) begin
            errors++; $display("FAIL static_dst beat %0d: valid=%b id=%0d, required 1/2", k, dst_valid, dst_src_id);
         end
      end
      tick();
      checks++;
      if (dst_valid !== 1'b0) begin errors++; $display("FAIL static_drain: valid=%b, required 0", dst_valid); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL static_pending: %0d beats, required 0", exp_q.size()); end
   endtask

   task automatic test_sel_switch_gap();
      mode = 1'b0; sel = 2'd2; dst_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         push_src(2, 10 + n, n == 2);
         push_exp(2, 10 + n, n == 2);
      end
      for (int n = 0; n < 2; n++) push_src(0, 20 + n, n == 1);
      for (int n = 0; n < 2; n++) push_exp(0, 20 + n, n == 1);
      drive();
      #1;
      tick();
      // Switch select and stall the locked source: src0 must not be served.
      sel = 2'd0; src_en[2] = 1'b0;
      drive();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (src_ready !== 4'b0100) begin errors++; $display("FAIL gap_src_ready: %b, required 0100", src_ready); end
         tick();
      end
      checks++;
      if (busy !== 1'b1 || dst_valid !== 1'b0) begin
         errors++; $display("FAIL gap_lock: busy=%b valid=%b, required 1/0", busy, dst_valid);
      end
      src_en[2] = 1'b1;
      drive();
      #1;
      tick();
      tick();
      checks++;
      if (src_ready !== 4'b0001 || busy !== 1'b0) begin
         errors++; $display("FAIL switch_regrant: ready=%b busy=%b, required 0001/0", src_ready, busy);
      end
      tick();
      checks++;
      if (dst_valid !== 1'b1 || dst_src_id !== 2'd0) begin
         errors++; $display("FAIL switch_src0: valid=%b id=%0d, required 1/0", dst_valid, dst_src_id);
      end
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL switch_pending: %0d beats, required 0", exp_q.size()); end
   endtask

   task automatic test_rr4();
      mode = 1'b1; sel = 2'd0; dst_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < NS; s++) begin
            push_src(s, 30 + r, 1'b1);
            push_exp(s, 30 + r, 1'b1);
         end
      end
      drive();
      #1;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (dst_valid !== 1'b1 || dst_src_id !== 2'(k % 4)) begin
            errors++; $display("FAIL rr4_order %0d: valid=%b id=%0d, required 1/%0d", k, dst_valid, dst_src_id, k % 4);
         end
      end
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rr4_pending: %0d beats, required 0", exp_q.size()); end
   endtask

   task automatic test_rr3_wrap();
      logic [2:0] pats [5];
      int         ids [5];
      exp_t       e;
      pats = '{3'b010, 3'b110, 3'b110, 3'b101, 3'b101};
      ids  = '{1, 2, 1, 2, 0};
      mode3 = 1'b1; dr3 = 1'b1; last3 = 3'b111;
      for (int i = 0; i < 3; i++) data3[i] = mk(i, 40);
      for (int k = 0; k < 5; k++) begin
         e.id = 2'(ids[k]); e.last = 1'b1; e.data = mk(ids[k], 40);
         exp3_q.push_back(e);
      end
      for (int k = 0; k < 5; k++) begin
         valid3 = pats[k];
         @(posedge clk);
         #1;
      end
      valid3 = '0;
      for (int k = 0; k < 10 && exp3_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp3_q.size() != 0 || busy3 !== 1'b0) begin
         errors++; $display("FAIL rr3_pending: %0d beats busy=%b, required 0/0", exp3_q.size(), busy3);
      end
   endtask

   task automatic test_backpressure();
      mode = 1'b0; sel = 2'd1; dst_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         push_src(1, 50 + n, n == 3);
         push_exp(1, 50 + n, n == 3);
      end
      drive();
      #1;
      tick();
      dst_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (dst_valid !== 1'b1 || dst_data !== mk(1, 50) || src_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold %0d: valid=%b ch0=%h ready=%b, required 1/%h/0000",
                               k, dst_valid, dst_data[0], src_ready, 24'h010000 | 24'(50 << 8));
         end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: %b, required 1", busy); end
      dst_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_pending: %0d beats busy=%b, required 0/0", exp_q.size(), busy);
      end
   endtask

   task automatic test_reset_mid_packet();
      mode = 1'b1; dst_ready = 1'b1;
      push_src(1, 60, 1'b1);
      push_exp(1, 60, 1'b1);
      push_src(2, 61, 1'b0);
      push_src(2, 62, 1'b1);
      drive();
      #1;
      tick();
      tick();
      dst_ready = 1'b0;
      checks++;
      if (busy !== 1'b1 || dst_src_id !== 2'd2) begin
         errors++; $display("FAIL mid_lock: busy=%b id=%0d, required 1/2", busy, dst_src_id);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (dst_valid !== 1'b0 || dst_last !== 1'b0 || dst_data !== '0 || dst_src_id !== 2'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset: valid=%b last=%b ch0=%h id=%0d busy=%b, required all 0",
                            dst_valid, dst_last, dst_data[0], dst_src_id, busy);
      end
      for (int i = 0; i < NS; i++) src_q[i].delete();
      exp_q.delete();
      drive();
      @(posedge clk);
      #1 rst_n = 1'b1;
      dst_ready = 1'b1;
      for (int s = 0; s < NS; s++) begin
         push_src(s, 70, 1'b1);
         push_exp(s, 70, 1'b1);
      end
      drive();
      #1;
      tick();
      checks++;
      if (dst_valid !== 1'b1 || dst_src_id !== 2'd0) begin
         errors++; $display("FAIL mid_first_grant: valid=%b id=%0d, required 1/0", dst_valid, dst_src_id);
      end
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pending: %0d beats, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_static_sel();
      test_sel_switch_gap();
      test_rr4();
      test_rr3_wrap();
      test_backpressure();
      test_reset_mid_packet();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/datapath_src_muxn_arb.md
Name: datapath_src_muxn_arb

Overview:
- N-source, packet-aware datapath mux with a registered output stage.
- Replaces the 2:1 combinational source select when more than two producers share one consumer, e.g. several line buffers or DMA read channels feeding one PE array input.
- Selection is either external (static select) or internal round-robin.
- Grant is locked for a whole packet (until a beat with last is accepted), so packets are never interleaved.

Parameters:
- DWID, 24, bits per channel element
- CH_NUM, 32, channels per beat
- SRC_NUM, 4, number of sources (2..16)
- SIDX_W, $clog2(SRC_NUM), localparam, source index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = external select, 1 = round-robin
- sel  in  SIDX_W  source index used in mode 0
- src_valid  in  SRC_NUM  per-source valid
- src_last  in  SRC_NUM  per-source end-of-packet
- src_data  in  [SRC_NUM][CH_NUM][DWID]  per-source beat
- src_ready  out  SRC_NUM  per-source ready
- dst_valid  out  1  output valid (registered)
- dst_last  out  1  output last (registered)
- dst_data  out  [CH_NUM][DWID]  output beat (registered)
- dst_src_id  out  SIDX_W  source index of the current output beat
- dst_ready  in  1  consumer ready
- busy  out  1  high while a packet is locked

Behaviour:
- Reset (async, rst_n=0): dst_valid=0, dst_last=0, dst_data=0, dst_src_id=0, busy=0, rr_ptr=0, state=IDLE. Reset mid-packet drops the partial packet; no recovery.
- States:
  - IDLE: no packet in flight.
  - LOCK: lock_src holds the granted source.
- Candidate cur_src:
  - LOCK: lock_src.
  - IDLE, mode 0: sel, valid only if sel < SRC_NUM; otherwise no candidate.
  - IDLE, mode 1: first index i with src_valid[i], scanning rr_ptr, rr_ptr+1, ..., wrapping modulo SRC_NUM; no candidate if no source is valid.
- mode and sel are sampled only in IDLE. Changes during LOCK take effect after the packet ends.
- Output stage accepts when !dst_valid || dst_ready (can_take).
- src_ready[i] = candidate exists && i == cur_src && can_take. All other bits are 0. src_ready may depend on src_valid in mode 1.
- Accept = src_valid[cur_src] && src_ready[cur_src].
- On accept: register dst_data, dst_last, dst_src_id from cur_src and set dst_valid=1.
- If dst_valid && dst_ready && !accept: dst_valid=0. dst_data holds its last value.
- Latency: 1 cycle from source beat to dst. Full throughput (1 beat/cycle) when dst_ready is held high.
- Transitions:
  - IDLE -> LOCK on accept with last=0; lock_src = cur_src, busy=1.
  - IDLE stays IDLE on accept with last=1 (single-beat packet).
  - LOCK -> IDLE on accept with last=1; busy=0.
- Round-robin pointer: on every accept with last=1 in mode 1, rr_ptr = (granted index + 1) mod SRC_NUM. The wrap from SRC_NUM-1 goes to 0, including non-power-of-2 SRC_NUM. rr_ptr is not updated in mode 0.
- A source dropping valid mid-packet keeps the lock: no beats are taken from others, and the block waits.
- Simultaneous dst_ready and accept: the new beat replaces the old beat in the same cycle, with no bubble.
- No data width conversion; all fields pass through unmodified.

Decomposition:
- Shared package (datapath_pkg) holds: typedef beat_t = logic [CH_NUM-1:0][DWID-1:0], the state enum {IDLE, LOCK}, and a constant for maximum SRC_NUM.
- One natural sub-module: rr_arb_pick, a combinational circular priority picker with inputs req[SRC_NUM] and ptr, and outputs idx and found.
- Lock FSM and output register stay in the top module.

Test Plan:
- Mode 0, sel=2, src2 sends 3-beat packet D0..D2 (last on D2), dst_ready=1 → dst shows D0,D1,D2 on cycles 1,2,3 after first valid; dst_src_id=2; src_ready=4'b0100 throughout; busy high for 2 cycles.
- Mode 0, sel switched 2→0 after beat 1 of a 3-beat src2 packet → remaining src2 beats complete first; src0 granted on the cycle after last is accepted.
- Mode 1, all four sources continuously valid with 1-beat packets → grant order 0,1,2,3,0,...; dst_src_id follows the same order at one per cycle.
- Mode 1, SRC_NUM=3, src1 and src2 valid, rr_ptr=2 → src2 served first, then src1; rr_ptr wraps 2→0.
- Backpressure: dst_ready=0 for 4 cycles mid-packet → dst_valid/dst_data held stable; src_ready=0; no beat lost or duplicated after release.
- rst_n asserted mid-packet → all outputs and busy are 0 immediately; after release, mode 1 grants src0 first.
